// File: rtl/hdlverifier_jtag_cmd_ctrl.sv
// rtl/hdlverifier_jtag_cmd_ctrl.sv - virtual-JTAG command sequencer: DR words in, bus requests out, read data back on tdo
module hdlverifier_jtag_cmd_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_FIFO_DEPTH = 16
) (
  input  logic                  tck,
  input  logic                  jtag_reset,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_write,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic [2:0]            err
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_CLR   = 4'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = 4;
  localparam logic [PW:0]           CNT_ONE   = 1;
  localparam logic [PW-1:0]         PTR_ONE   = 1;
  localparam logic [4:0]            LAST_BIT  = 5'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] in_sr_q, in_sr_d;
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic                  word_vld_q, word_vld_d;
  logic [DATA_WIDTH-1:0] out_sr_q, out_sr_d;
  logic                  tdo_q, tdo_d;
  logic [2:0]            state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [7:0]            beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [2:0]            err_q, err_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [RD_FIFO_DEPTH];

  logic                  word_done, hs, push, pop, reload, wdata_last;
  logic [3:0]            opcode;
  logic [7:0]            cnt8;
  logic [DATA_WIDTH-1:0] status;

  always_comb begin
    word_done = shift_dr && (bitcnt_q == LAST_BIT);
    hs        = cmd_valid_q && cmd_ready;
    opcode    = in_sr_q[31:28];
    push      = (state_q == S_RD_WAIT) && rd_valid;
    reload    = capture_dr || word_done;
    pop       = reload && (count_q != '0);
    cnt8      = 8'(count_q);
    status    = {(state_q != S_IDLE), err_q, 20'b0, cnt8};

    in_sr_d     = in_sr_q;
    bitcnt_d    = bitcnt_q;
    word_vld_d  = word_done;
    out_sr_d    = out_sr_q;
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    beats_d     = beats_q;
    addr_d      = addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    err_d       = err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wdata_last  = 1'b0;

    if (shift_dr) begin
      in_sr_d  = {tdi, in_sr_q[DATA_WIDTH-1:1]};
      bitcnt_d = bitcnt_q + 5'd1;
      out_sr_d = {1'b0, out_sr_q[DATA_WIDTH-1:1]};
    end
    if (capture_dr || update_dr) bitcnt_d = '0;
    if (reload) out_sr_d = pop ? fifo_mem_q[rd_ptr_q] : status;
    tdo_d = out_sr_d[0];

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: ;
    endcase

    // A handshake always retires the request, even one left over from an aborted write.
    if (hs) cmd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (word_vld_q) begin
          case (opcode)
            OP_NOP: ;
            OP_WRITE, OP_READ: begin
              is_wr_d = (opcode == OP_WRITE);
              beats_d = in_sr_q[7:0];
              state_d = S_ADDR;
            end
            OP_CLR:  err_d = 3'b000;
            default: err_d[2] = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (update_dr) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else if (word_vld_q) begin
          addr_d  = in_sr_q[ADDR_WIDTH-1:0];
          state_d = is_wr_q ? S_WDATA : S_RD_REQ;
        end
      end
      S_WDATA: begin
        if (update_dr) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          if (hs && cmd_write_q) begin
            addr_d  = addr_q + ADDR_STEP;
            beats_d = beats_q - 8'd1;
            if (beats_q == 8'd0) begin
              wdata_last = 1'b1;
              state_d    = S_IDLE;
            end
          end
          // A beat retiring this very cycle frees the slot for the new word.
          if (word_vld_q) begin
            if ((cmd_valid_q && !hs) || wdata_last) begin
              err_d[1] = 1'b1;
            end else begin
              cmd_valid_d = 1'b1;
              cmd_write_d = 1'b1;
              cmd_wdata_d = in_sr_q;
              cmd_addr_d  = addr_d;
            end
          end
        end
      end
      S_RD_REQ: begin
        if (word_vld_q && opcode != OP_NOP) err_d[1] = 1'b1;
        if (hs && !cmd_write_q) begin
          state_d = S_RD_WAIT;
        end else if (!cmd_valid_q && !count_q[PW]) begin
          // Nothing is outstanding here, so a non-full FIFO has room for the reply.
          cmd_valid_d = 1'b1;
          cmd_write_d = 1'b0;
          cmd_addr_d  = addr_q;
        end
      end
      S_RD_WAIT: begin
        if (word_vld_q && opcode != OP_NOP) err_d[1] = 1'b1;
        if (rd_valid) begin
          addr_d  = addr_q + ADDR_STEP;
          beats_d = beats_q - 8'd1;
          state_d = (beats_q == 8'd0) ? S_IDLE : S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tck) begin
    if (jtag_reset) begin
      in_sr_q     <= '0;
      bitcnt_q    <= '0;
      word_vld_q  <= 1'b0;
      out_sr_q    <= '0;
      tdo_q       <= 1'b0;
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      beats_q     <= '0;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      err_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      in_sr_q     <= in_sr_d;
      bitcnt_q    <= bitcnt_d;
      word_vld_q  <= word_vld_d;
      out_sr_q    <= out_sr_d;
      tdo_q       <= tdo_d;
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      beats_q     <= beats_d;
      addr_q      <= addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge tck) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rd_data;
  end

  assign tdo       = tdo_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_hdlverifier_jtag_cmd_ctrl.sv
// tb/tb_hdlverifier_jtag_cmd_ctrl.sv - scoreboard bench for the JTAG command sequencer
module tb_hdlverifier_jtag_cmd_ctrl;

  logic        tck = 1'b0;
  logic        jtag_reset = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        capture_dr = 1'b0;
  logic        shift_dr = 1'b0;
  logic        update_dr = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        busy;
  logic [2:0]  err;

  hdlverifier_jtag_cmd_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_FIFO_DEPTH(16)) dut (
    .tck(tck), .jtag_reset(jtag_reset), .tdi(tdi), .tdo(tdo),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err)
  );

  always #5 tck = ~tck;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_tdo[$];
  logic [31:0] rd_resp[$];
  logic [31:0] pend[$];
  int          checks = 0;
  int          errors = 0;
  int          n_hs = 0;
  int          tdo_cnt = 0;
  logic        tdo_chk = 1'b0;
  logic [31:0] tdo_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge tck);
    #1;
  endtask

  task automatic shift_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      tdi = w[i];
      shift_dr = 1'b1;
      @(posedge tck);
      #1;
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic capture();
    capture_dr = 1'b1;
    @(posedge tck);
    #1;
    capture_dr = 1'b0;
  endtask

  task automatic pulse_update();
    update_dr = 1'b1;
    @(posedge tck);
    #1;
    update_dr = 1'b0;
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_cmd.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [31:0] d);
    exp_cmd.push_back('{wr: 1'b0, addr: a, data: 32'h0});
    rd_resp.push_back(d);
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_hs < target && k < budget) begin
      @(posedge tck);
      #2;
      k++;
    end
    chk(name, 32'(n_hs), 32'(target));
  endtask

  // Monitor: checks every bus handshake and every completed tdo word against the scoreboard.
  initial forever begin
    cmd_t e;
    @(negedge tck);
    if (jtag_reset) begin
      tdo_cnt = 0;
    end else begin
      if (capture_dr) tdo_cnt = 0;
      if (shift_dr) begin
        tdo_word[tdo_cnt] = tdo;
        tdo_cnt++;
        if (tdo_cnt == 32) begin
          tdo_cnt = 0;
          if (tdo_chk) begin
            if (exp_tdo.size() == 0) fail_now("tdo_unexpected_word");
            else chk("tdo_word", tdo_word, exp_tdo.pop_front());
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        n_hs++;
        if (exp_cmd.size() == 0) begin
          fail_now("cmd_unexpected");
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd_write", {31'b0, cmd_write}, {31'b0, e.wr});
          chk("cmd_addr", cmd_addr, e.addr);
          if (e.wr) chk("cmd_wdata", cmd_wdata, e.data);
        end
        if (!cmd_write) begin
          if (rd_resp.size() == 0) fail_now("rd_resp_missing");
          else pend.push_back(rd_resp.pop_front());
        end
      end
    end
  end

  // Memory model: returns read data one cycle after the accepting edge.
  initial forever begin
    @(posedge tck);
    #1;
    rd_valid = 1'b0;
    if (pend.size() > 0) begin
      rd_valid = 1'b1;
      rd_data  = pend.pop_front();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    tick(3);
    chk("rst_tdo", {31'b0, tdo}, 32'h0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_err", {29'b0, err}, 32'h0);
    chk("rst_cmd_addr", cmd_addr, 32'h0);
    jtag_reset = 1'b0;
    tick(2);

    // Two-beat write.
    exp_wr(32'h100, 32'hA5A5A5A5);
    exp_wr(32'h104, 32'h5A5A5A5A);
    capture();
    shift_word(32'h1000_0001);
    shift_word(32'h0000_0100);
    shift_word(32'hA5A5A5A5);
    shift_word(32'h5A5A5A5A);
    tick(6);
    chk("wr_hs_count", 32'(n_hs), 32'd2);
    chk("wr_busy", {31'b0, busy}, 32'h0);
    chk("wr_err", {29'b0, err}, 32'h0);

    // Three-beat read, drained through tdo; the fourth word is the empty status.
    base = n_hs;
    exp_rd(32'h2000, 32'h11);
    exp_rd(32'h2004, 32'h22);
    exp_rd(32'h2008, 32'h33);
    capture();
    shift_word(32'h2000_0002);
    shift_word(32'h0000_2000);
    wait_hs(base + 3, 200, "rd3_hs_count");
    tick(4);
    chk("rd3_busy", {31'b0, busy}, 32'h0);
    exp_tdo.push_back(32'h11);
    exp_tdo.push_back(32'h22);
    exp_tdo.push_back(32'h33);
    exp_tdo.push_back(32'h0);
    tdo_chk = 1'b1;
    capture();
    for (int i = 0; i < 4; i++) shift_word(32'h0);
    tdo_chk = 1'b0;

    // Twenty-beat read stalls at FIFO depth, then completes while the host drains.
    base = n_hs;
    for (int i = 0; i < 20; i++) exp_rd(32'h8000 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    capture();
    shift_word(32'h2000_0013);
    shift_word(32'h0000_8000);
    wait_hs(base + 16, 400, "rd20_first16");
    tick(50);
    chk("rd20_stall_count", 32'(n_hs - base), 32'd16);
    chk("rd20_stall_valid", {31'b0, cmd_valid}, 32'h0);
    chk("rd20_stall_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 20; i++) exp_tdo.push_back(32'hC000_0000 + 32'(i));
    exp_tdo.push_back(32'h0);
    tdo_chk = 1'b1;
    capture();
    for (int i = 0; i < 21; i++) shift_word(32'h0);
    tdo_chk = 1'b0;
    tick(3);
    chk("rd20_total", 32'(n_hs - base), 32'd20);
    chk("rd20_busy", {31'b0, busy}, 32'h0);

    // Overrun: second data word arrives while the first is still pending.
    cmd_ready = 1'b0;
    exp_wr(32'h300, 32'hDEAD0001);
    capture();
    shift_word(32'h1000_0000);
    shift_word(32'h0000_0300);
    shift_word(32'hDEAD0001);
    shift_word(32'hDEAD0002);
    tick(6);
    chk("ovr_err", {29'b0, err}, 32'h2);
    chk("ovr_valid_held", {31'b0, cmd_valid}, 32'h1);
    cmd_ready = 1'b1;
    tick(3);
    chk("ovr_busy", {31'b0, busy}, 32'h0);
    capture();
    shift_word(32'h3000_0000);
    tick(3);
    chk("clr_err", {29'b0, err}, 32'h0);

    // Illegal opcode, visible in the status word.
    capture();
    shift_word(32'h7000_0000);
    tick(3);
    chk("badop_err", {29'b0, err}, 32'h4);
    chk("badop_busy", {31'b0, busy}, 32'h0);
    exp_tdo.push_back(32'h4000_0000);
    tdo_chk = 1'b1;
    capture();
    shift_word(32'h0);
    tdo_chk = 1'b0;
    shift_word(32'h3000_0000);
    tick(3);
    chk("badop_clr", {29'b0, err}, 32'h0);

    // Abort between address and data.
    capture();
    shift_word(32'h1000_0001);
    shift_word(32'h0000_0400);
    tick(2);
    chk("abort_pre_busy", {31'b0, busy}, 32'h1);
    pulse_update();
    tick(1);
    chk("abort_err", {29'b0, err}, 32'h1);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    tick(10);
    chk("abort_no_valid", {31'b0, cmd_valid}, 32'h0);
    capture();
    shift_word(32'h3000_0000);
    tick(3);

    // Reset mid-read with a pending request and buffered data.
    base = n_hs;
    exp_rd(32'h600, 32'h55);
    exp_rd(32'h604, 32'h66);
    capture();
    shift_word(32'h2000_0007);
    shift_word(32'h0000_0600);
    wait_hs(base + 2, 100, "rst_setup_hs");
    cmd_ready = 1'b0;
    k = 0;
    while (cmd_valid !== 1'b1 && k < 50) begin
      @(posedge tck);
      #2;
      k++;
    end
    chk("rst_setup_valid", {31'b0, cmd_valid}, 32'h1);
    jtag_reset = 1'b1;
    @(posedge tck);
    #1;
    jtag_reset = 1'b0;
    chk("rst2_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    chk("rst2_busy", {31'b0, busy}, 32'h0);
    chk("rst2_err", {29'b0, err}, 32'h0);
    chk("rst2_tdo", {31'b0, tdo}, 32'h0);
    chk("rst2_cmd_addr", cmd_addr, 32'h0);
    chk("rst2_cmd_wdata", cmd_wdata, 32'h0);
    cmd_ready = 1'b1;
    exp_tdo.push_back(32'h0);
    tdo_chk = 1'b1;
    capture();
    shift_word(32'h0);
    tdo_chk = 1'b0;
    tick(5);

    chk("exp_cmd_drained", 32'(exp_cmd.size()), 32'd0);
    chk("exp_tdo_drained", 32'(exp_tdo.size()), 32'd0);
    chk("rd_resp_drained", 32'(rd_resp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlverifier_jtag_cmd_ctrl.md
Name: hdlverifier_jtag_cmd_ctrl

Overview:
- Command sequencer behind the virtual-JTAG vendor wrapper, running entirely in the tck domain.
- Deserializes 32-bit DR words shifted in on tdi into header/address/data frames.
- Issues single-beat memory-mapped write/read requests on a valid/ready bus.
- Buffers read responses in a small FIFO and serializes them back out on tdo.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr; byte address, incremented by 4 per beat.
- DATA_WIDTH, 32, word size; fixed at 32, sets JTAG word length.
- RD_FIFO_DEPTH, 16, read-response FIFO entries; power of two, at least 2.

Ports:
- tck  in  1  sole clock, from the JTAG wrapper.
- jtag_reset  in  1  reset; synchronous, active-high.
- tdi  in  1  serial data in, LSB first.
- tdo  out  1  serial data out, LSB first.
- capture_dr  in  1  virtual capture-DR state.
- shift_dr  in  1  virtual shift-DR state.
- update_dr  in  1  virtual update-DR state.
- cmd_valid  out  1  request valid.
- cmd_ready  in  1  request accepted when high together with cmd_valid.
- cmd_write  out  1  1 = write, 0 = read.
- cmd_addr  out  ADDR_WIDTH  request byte address.
- cmd_wdata  out  32  write data.
- rd_valid  in  1  read data valid; one pulse per accepted read.
- rd_data  in  32  read data.
- busy  out  1  high when FSM is not in IDLE.
- err  out  3  sticky flags: {bad_op, overrun, abort}.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; bit counter 0; FIFO empty; tdo 0.
- Deserializer:
  - Each tck with shift_dr high: in_sr <= {tdi, in_sr[31:1]}; bitcnt++ (5-bit, wraps).
  - Shifting with bitcnt==31 completes a word. word_vld pulses the next cycle with word = in_sr.
  - capture_dr or update_dr clears bitcnt; a partial word is discarded.
- Header word format:
  - [31:28] opcode: 0 = NOP, 1 = WRITE, 2 = READ, 3 = CLR_ERR.
  - [7:0] = beats-1, giving 1..256 beats.
  - Other bits are ignored.
- FSM states: IDLE, ADDR, WDATA, RD_REQ, RD_WAIT.
- IDLE, on word_vld:
  - NOP: ignored.
  - WRITE or READ: latch opcode and length, go to ADDR.
  - CLR_ERR: err <= 0.
  - Other opcode: set bad_op, stay IDLE.
- ADDR, on word_vld: addr <= word[ADDR_WIDTH-1:0]; go to WDATA if WRITE, else RD_REQ.
- WDATA, on word_vld:
  - If cmd_valid is low: next cycle cmd_valid=1, cmd_write=1, cmd_wdata=word, cmd_addr=addr.
  - If cmd_valid is still high (previous beat not accepted): set overrun, drop the word, do not decrement beats.
  - On handshake: cmd_valid<=0, addr+=4, beats--. After the last beat handshake, go to IDLE.
- RD_REQ:
  - Assert cmd_valid (cmd_write=0) only if FIFO count + outstanding < RD_FIFO_DEPTH; otherwise hold cmd_valid low. Read data is never dropped.
  - On handshake: go to RD_WAIT.
- RD_WAIT:
  - On rd_valid: push rd_data; addr+=4; beats--.
  - Go to RD_REQ if beats remain, else IDLE.
  - rd_valid in any other state is ignored.
- word_vld in RD_REQ/RD_WAIT: NOP words are ignored silently; non-NOP words set overrun and are dropped.
- update_dr while in ADDR or WDATA:
  - Set abort; go to IDLE.
  - A pending cmd_valid stays until its handshake, then is cleared; remaining beats are discarded.
- update_dr while in RD_REQ/RD_WAIT: no effect; the read completes.
- Serializer:
  - out_sr is reloaded on capture_dr, and on each word completion (bitcnt==31 while shifting).
  - Reload value is the FIFO head (pop) if non-empty, else the status word {busy, err[2:0], 20'b0, count[7:0]}.
  - Shifting: out_sr >> 1. tdo = out_sr[0], registered.
- Simultaneous push and pop: both occur; count is unchanged.
- Address wraps modulo 2^ADDR_WIDTH.
- jtag_reset at any time returns everything to reset values, including a pending cmd_valid.
- Latency:
  - Last tdi bit of a data word to cmd_valid: 2 cycles.
  - rd_valid to FIFO visible: 1 cycle.

Test Plan:
- Shift WRITE len=2, addr 0x100, data 0xA5A5A5A5, 0x5A5A5A5A, with cmd_ready=1 -> two handshakes: (0x100, 0xA5A5A5A5) then (0x104, 0x5A5A5A5A); busy falls; err=0.
- READ len=3 @0x2000 with rd_data = 0x11, 0x22, 0x33, then shift 3 NOP words -> tdo words read back 0x11, 0x22, 0x33; the 4th word shifted is the status word with count=0.
- READ len=20 with RD_FIFO_DEPTH=16 and no host shifting -> exactly 16 reads issued and cmd_valid held low; shift 4 words -> remaining 4 reads issued; no data lost.
- WRITE with cmd_ready held low for 40 cycles -> second data word dropped and err=3'b010; CLR_ERR header -> err=0.
- Header opcode 0x7 -> err=3'b100, FSM stays IDLE. WRITE header + address, then update_dr -> err abort bit set, FSM IDLE, no cmd_valid.
- jtag_reset asserted in RD_WAIT with cmd_valid and FIFO non-empty -> next cycle all outputs 0, FIFO empty, busy=0.
